// File: rtl/cr16_alu_pkg.sv
// ----------------------------------------------------------------------------
// cr16_alu_pkg
// Shared definitions for the CR16 sequential ALU:
//   - opcode encodings presented on the 4-bit op port
//   - bit positions of the PSR flags inside the 5-bit flags word {C,L,F,Z,N}
//   - FSM state encoding used by alu_seq_core
// ----------------------------------------------------------------------------
package cr16_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// ----------------------------------------------------------------------------
// alu_addsub
// Combinational WIDTH-bit adder/subtractor shared by ADD, SUB, CMP and the
// MUL accumulate step.
// Ports:
//   x, y  in   WIDTH  operands
//   sub   in   1      0: sum = x + y, 1: sum = x - y
//   sum   out  WIDTH  result
//   cb    out  1      carry out (add) or borrow, i.e. x < y unsigned (sub)
//   ovf   out  1      two's-complement overflow of the operation
// ----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cb,
    output logic             ovf
);

    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;

    always_comb begin
        yy   = sub ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
        sum  = full[WIDTH-1:0];
        // Subtraction is x + ~y + 1, so a missing carry means a borrow.
        cb   = sub ? ~full[WIDTH] : full[WIDTH];
        // Overflow when both effective addends share a sign the sum lacks.
        ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

// File: rtl/alu_seq_core.sv
// ----------------------------------------------------------------------------
// alu_seq_core
// Multi-cycle ALU for the CR16 datapath. Logic ops, ADD/SUB/CMP and zero-
// amount shifts complete at the accept edge; non-zero shifts run one bit per
// clock and MUL runs as WIDTH shift-add steps. Result and PSR flags are held
// in registers until the next operation.
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous active-high reset
//   start   in   1      accept op/a/b while idle
//   op      in   4      opcode (see cr16_alu_pkg)
//   a, b    in   WIDTH  operands; b[SHAMT_W-1:0] is the shift amount
//   busy    out  1      multi-cycle operation in progress
//   done    out  1      one-cycle pulse, result/flags valid
//   result  out  WIDTH  registered result
//   flags   out  5      registered {C,L,F,Z,N}
// ----------------------------------------------------------------------------
module alu_seq_core
    import cr16_alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ENABLE_MUL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   result_n;
    logic [4:0]         flags_n;
    logic               done_n;
    logic [WIDTH-1:0]   work, work_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]   mplier, mplier_n;
    logic [3:0]         sop, sop_n;
    logic [WIDTH-1:0]   shifted;

    logic [WIDTH-1:0]   add_x, add_y, add_sum;
    logic               add_sub, add_cb, add_ovf;
    logic [SHAMT_W-1:0] shamt;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] o,
                                                input logic [WIDTH-1:0] v);
        case (o)
            OP_SLL:  return v << 1;
            OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v >> 1;
        endcase
    endfunction

    assign shamt = b[SHAMT_W-1:0];
    assign busy  = (state != ST_IDLE);

    // While multiplying, the adder accumulates the shifted multiplicand
    // whenever the current multiplier bit is set; otherwise it serves a/b.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_sub = (op != OP_ADD);
        if (state == ST_MUL) begin
            add_x   = acc;
            add_y   = mplier[0] ? mcand : '0;
            add_sub = 1'b0;
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (add_x),
        .y   (add_y),
        .sub (add_sub),
        .sum (add_sum),
        .cb  (add_cb),
        .ovf (add_ovf)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        result_n = result;
        flags_n  = flags;
        done_n   = 1'b0;
        work_n   = work;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        sop_n    = sop;
        shifted  = shift1(sop, work);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    done_n = 1'b1;
                    case (op)
                        OP_ADD, OP_SUB: begin
                            result_n       = add_sum;
                            flags_n[FLG_C] = add_cb;
                            flags_n[FLG_F] = add_ovf;
                        end
                        OP_CMP: begin
                            flags_n[FLG_L] = add_cb;
                            // Signed less-than: sign of a-b corrected by overflow.
                            flags_n[FLG_N] = add_sum[WIDTH-1] ^ add_ovf;
                            flags_n[FLG_Z] = (add_sum == '0);
                        end
                        OP_AND: result_n = a & b;
                        OP_OR:  result_n = a | b;
                        OP_XOR: result_n = a ^ b;
                        OP_SLL, OP_SRA, OP_SRL: begin
                            if (shamt == '0) begin
                                result_n = a;
                            end else begin
                                done_n  = 1'b0;
                                work_n  = a;
                                sop_n   = op;
                                cnt_n   = {1'b0, shamt};
                                state_n = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            if (ENABLE_MUL != 0) begin
                                done_n   = 1'b0;
                                acc_n    = '0;
                                mcand_n  = a;
                                mplier_n = b;
                                cnt_n    = CNT_W'(WIDTH);
                                state_n  = ST_MUL;
                            end else begin
                                result_n = '0;
                            end
                        end
                        default: result_n = '0;
                    endcase
                end
            end
            ST_SHIFT: begin
                work_n = shifted;
                cnt_n  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    result_n = shifted;
                    done_n   = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_n    = add_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    result_n = add_sum;
                    done_n   = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done   <= done_n;
            result <= result_n;
            flags  <= flags_n;
        end
    end

    // Working registers are always loaded before use, so they need no reset.
    always_ff @(posedge clk) begin
        work   <= work_n;
        acc    <= acc_n;
        mcand  <= mcand_n;
        mplier <= mplier_n;
        sop    <= sop_n;
    end

endmodule
